// File: rtl/core_featuremap_conv_mac.sv
// core_featuremap_conv_mac: CH-channel KTAPS-tap MAC with bias, rescale, saturation and output back-pressure.
// Optional CONV_RELU_EN clamps negative results to zero before they are registered.
module core_featuremap_conv_mac #(
    parameter int DWIDTH = 16,
    parameter int CH     = 8,
    parameter int KTAPS  = 9,
    parameter int FRAC   = 8,
    parameter int AWIDTH = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CH*DWIDTH-1:0] ff_rdata,
    input  logic [CH-1:0]        ff_empty,
    output logic                 ff_rdreq,
    output logic [DWIDTH-1:0]    ff_wdata,
    output logic                 ff_wrreq,
    input  logic                 ff_full,
    input  logic                 cfg_we,
    input  logic [AWIDTH-1:0]    cfg_addr,
    input  logic [DWIDTH-1:0]    cfg_wdata,
    input  logic                 cfg_bias_we,
    output logic                 busy
);
    localparam int NW   = CH * KTAPS;
    localparam int ACCW = 2 * DWIDTH + $clog2(NW);
    localparam int TW   = KTAPS > 1 ? $clog2(KTAPS) : 1;
    localparam logic signed [ACCW-1:0] MAXV = ACCW'((64'sd1 <<< (DWIDTH - 1)) - 64'sd1);
    localparam logic signed [ACCW-1:0] MINV = -MAXV - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                     state, state_d;
    logic [TW-1:0]              tap;
    logic signed [ACCW-1:0]     acc, sum, acc_nx, total, shifted;
    logic signed [DWIDTH-1:0]   w [NW];
    logic signed [DWIDTH-1:0]   bias, sat, res;
    logic signed [2*DWIDTH-1:0] prod [CH];
    logic                       fire, last;

    assign fire = &(~ff_empty);
    assign last = tap == TW'(KTAPS - 1);
    assign busy = state != IDLE;

    always_comb begin
        sum = '0;
        for (int c = 0; c < CH; c++) begin
            prod[c] = $signed(ff_rdata[c*DWIDTH +: DWIDTH]) * w[AWIDTH'(c * KTAPS + int'(tap))];
            sum = sum + ACCW'(prod[c]);
        end
    end

    // Bias is aligned to the product scale (2*FRAC) before the single floor shift back to FRAC.
    assign acc_nx  = acc + sum;
    assign total   = acc_nx + (ACCW'(bias) <<< FRAC);
    assign shifted = total >>> FRAC;
    assign sat     = shifted > MAXV ? DWIDTH'(MAXV) : shifted < MINV ? DWIDTH'(MINV) : DWIDTH'(shifted);
`ifdef CONV_RELU_EN
    assign res = sat[DWIDTH-1] ? '0 : sat;
`else
    assign res = sat;
`endif

    always_comb begin
        state_d  = state;
        ff_rdreq = 1'b0;
        ff_wrreq = 1'b0;
        case (state)
            IDLE:  state_d = enable ? ACCUM : IDLE;
            ACCUM: begin
                ff_rdreq = fire;
                state_d  = fire && last ? OUT : ACCUM;
            end
            OUT: begin
                ff_wrreq = ~ff_full;
                state_d  = ff_full ? OUT : enable ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tap      <= '0;
            acc      <= '0;
            bias     <= '0;
            ff_wdata <= '0;
            w        <= '{default: '0};
        end else begin
            state <= state_d;
            if (state == ACCUM && fire) begin
                acc <= acc_nx;
                tap <= last ? '0 : tap + 1'b1;
                if (last) ff_wdata <= res;
            end
            if (state == OUT && !ff_full) acc <= '0;
            if (state == IDLE && cfg_we && int'(cfg_addr) < NW) w[cfg_addr] <= cfg_wdata;
            if (state == IDLE && cfg_bias_we) bias <= cfg_wdata;
        end
    end
endmodule

// File: tb/tb_core_featuremap_conv_mac.sv
// tb_core_featuremap_conv_mac: directed bench for the default 8-channel, 9-tap configuration.
module tb_core_featuremap_conv_mac;
    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [127:0]  ff_rdata;
    logic [7:0]    ff_empty;
    logic          ff_rdreq;
    logic [15:0]   ff_wdata;
    logic          ff_wrreq;
    logic          ff_full = 1'b0;
    logic          cfg_we = 1'b0;
    logic [6:0]    cfg_addr = '0;
    logic [15:0]   cfg_wdata = '0;
    logic          cfg_bias_we = 1'b0;
    logic          busy;

    logic [15:0]   din = '0;
    logic [7:0]    stall = '0;
    logic [15:0]   last_w = '0;
    int            avail = 0;
    int            pops = 0;
    int            writes = 0;
    int            ncyc = 0;
    int            checks = 0;
    int            errors = 0;

`ifdef CONV_RELU_EN
    localparam logic [15:0] EXP_NEG = 16'h0000;
    localparam logic [15:0] EXP_MIN = 16'h0000;
`else
    localparam logic [15:0] EXP_NEG = 16'hC000;
    localparam logic [15:0] EXP_MIN = 16'h8000;
`endif

    assign ff_rdata = {8{din}};
    assign ff_empty = (avail == 0) ? 8'hFF : stall;

    always #5 clock = ~clock;

    core_featuremap_conv_mac dut (
        .clock(clock), .reset(reset), .enable(enable),
        .ff_rdata(ff_rdata), .ff_empty(ff_empty), .ff_rdreq(ff_rdreq),
        .ff_wdata(ff_wdata), .ff_wrreq(ff_wrreq), .ff_full(ff_full),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_bias_we(cfg_bias_we), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Observe handshakes mid-cycle, then advance past the next rising edge.
    task automatic tick();
        logic p;
        @(negedge clock);
        p = ff_rdreq;
        if (ff_wrreq) begin
            writes++;
            last_w = ff_wdata;
        end
        @(posedge clock);
        #1;
        ncyc++;
        if (p) begin
            pops++;
            avail--;
        end
    endtask

    task automatic load_w(input logic [15:0] v);
        for (int i = 0; i < 72; i++) begin
            cfg_we = 1'b1;
            cfg_addr = 7'(i);
            cfg_wdata = v;
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic load_b(input logic [15:0] v);
        cfg_bias_we = 1'b1;
        cfg_wdata = v;
        tick();
        cfg_bias_we = 1'b0;
    endtask

    task automatic run(input bit hold);
        int st;
        st = writes;
        enable = 1'b1;
        tick();
        if (!hold) enable = 1'b0;
        for (int i = 0; i < 200 && writes == st; i++) tick();
        check("run_done", 32'(writes - st), 32'd1);
    endtask

    task automatic wait_pops(input int n);
        for (int i = 0; i < 200 && pops < n; i++) tick();
        check("pop_wait", 32'(pops), 32'(n));
    endtask

    initial begin
        int c0, d0, st;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wdata", 32'(ff_wdata), 32'd0);
        check("rst_rdreq", 32'(ff_rdreq), 32'd0);
        check("rst_wrreq", 32'(ff_wrreq), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Unit weights over 72 products give 72.0.
        load_w(16'h0100);
        load_b(16'h0000);
        din = 16'h0100;
        avail = 9;
        pops = 0;
        run(1'b1);
        check("def_pops", 32'(pops), 32'd9);
        check("def_wdata", 32'(last_w), 32'h4800);
        repeat (3) tick();
        check("def_busy", 32'(busy), 32'd1);
        check("def_nopop", 32'(pops), 32'd9);
        enable = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // -72.0 + 8.0 = -64.0
        load_w(16'hFF00);
        load_b(16'h0800);
        avail = 9;
        run(1'b0);
        check("neg_bias", 32'(last_w), 32'(EXP_NEG));
        check("neg_idle", 32'(busy), 32'd0);

        load_b(16'h0000);
        load_w(16'h7FFF);
        din = 16'h7FFF;
        avail = 9;
        run(1'b0);
        check("sat_pos", 32'(last_w), 32'h7FFF);
        load_w(16'h8000);
        avail = 9;
        run(1'b0);
        check("sat_neg", 32'(last_w), 32'(EXP_MIN));

        // Starvation: stall channel 3 for 4 cycles at tap 5.
        load_w(16'h0100);
        din = 16'h0100;
        avail = 9;
        c0 = ncyc;
        run(1'b0);
        d0 = ncyc - c0;
        check("ref_wdata", 32'(last_w), 32'h4800);
        avail = 9;
        pops = 0;
        c0 = ncyc;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_pops(5);
        stall = 8'h08;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("stall_rdreq", 32'(ff_rdreq), 32'd0);
            tick();
        end
        check("stall_pops", 32'(pops), 32'd5);
        stall = 8'h00;
        st = writes;
        for (int i = 0; i < 200 && writes == st; i++) tick();
        check("stall_write", 32'(writes - st), 32'd1);
        check("stall_delay", 32'(ncyc - c0), 32'(d0 + 4));
        check("stall_wdata", 32'(last_w), 32'h4800);

        // Back-pressure with more data waiting upstream.
        last_w = 16'h0000;
        ff_full = 1'b1;
        avail = 18;
        pops = 0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_pops(9);
        st = writes;
        for (int i = 0; i < 5; i++) begin
            check("bp_wrreq", 32'(ff_wrreq), 32'd0);
            check("bp_rdreq", 32'(ff_rdreq), 32'd0);
            check("bp_wdata", 32'(ff_wdata), 32'h4800);
            tick();
        end
        ff_full = 1'b0;
        repeat (4) tick();
        check("bp_writes", 32'(writes - st), 32'd1);
        check("bp_word", 32'(last_w), 32'h4800);
        check("bp_pops", 32'(pops), 32'd9);
        check("bp_idle", 32'(busy), 32'd0);

        // Config write during ACCUM is ignored; reset mid-window clears everything.
        avail = 18;
        pops = 0;
        enable = 1'b1;
        tick();
        cfg_we = 1'b1;
        cfg_addr = 7'd0;
        cfg_wdata = 16'h7FFF;
        tick();
        cfg_we = 1'b0;
        st = writes;
        for (int i = 0; i < 200 && writes == st; i++) tick();
        check("cfg_ignored", 32'(last_w), 32'h4800);
        wait_pops(13);
        reset = 1'b1;
        #1;
        check("arst_rdreq", 32'(ff_rdreq), 32'd0);
        check("arst_wrreq", 32'(ff_wrreq), 32'd0);
        check("arst_wdata", 32'(ff_wdata), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        enable = 1'b0;
        avail = 0;
        tick();
        reset = 1'b0;
        last_w = 16'hFFFF;
        avail = 9;
        run(1'b0);
        check("cleared_w", 32'(last_w), 32'd0);
        load_w(16'h0100);
        avail = 9;
        run(1'b0);
        check("reload", 32'(last_w), 32'h4800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
